// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, round transforms,
// key schedule and the controller state encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TBL_INIT,
    ROUND,
    OUT
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 by square-and-multiply; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    unique case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] k,
                                                  input logic [3:0] round);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]),
          aes_sbox(w3[7:0]), aes_sbox(w3[31:24])}
         ^ {rcon(round), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_masked_sbox_table.sv
// Masked S-box storage: one fill write port, LANES
// combinational read ports (lane j at raddr[8j +: 8]).
module aes_masked_sbox_table #(
  parameter int LANES = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [7:0]         waddr,
  input  logic [7:0]         wdata,
  input  logic [8*LANES-1:0] raddr,
  output logic [8*LANES-1:0] rdata
);

  logic [7:0] mem [256];

  // table fill, one entry per cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar j = 0; j < LANES; j++) begin : g_rd
    assign rdata[8*j +: 8] = mem[raddr[8*j +: 8]];
  end

endmodule

// File: rtl/aes128_masked_lanes.sv
// Masked AES-128 encryptor with configurable S-box lanes,
// masked-table reuse and optional temporal redundancy.
module aes128_masked_lanes
  import aes_pkg::*;
#(
  parameter int SBOX_LANES   = 16,
  parameter int FAULT_DETECT = 0,
  parameter int MASK_REUSE   = 1,
  parameter int FAULT_ROUND  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  input  logic [7:0]   mask_byte,
  input  logic         fault_inject,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         fault,
  output logic         busy
);

  localparam int LC = 16 / SBOX_LANES;
  localparam int LW = 8 * SBOX_LANES;
  localparam bit FD = (FAULT_DETECT != 0);

  state_e st_q, st_d;
  logic [127:0] ste, ste_save, rkey, key_save;
  logic [127:0] mask_reg, sb, res0, ct_q;
  logic [3:0]   round, lane;
  logic [8:0]   fill;
  logic [7:0]   r_q, cached_r;
  logic         pass, tbl_valid, fault_q;

  logic         need_fill, last_lane, done, flip, mismatch;
  logic [6:0]   sh;
  logic [LW-1:0] raddr, rdata, rd_msb;
  logic [127:0] st_sh, rd_wide, lmask, sb_full;
  logic [127:0] sr, nk, st_new, mask_new, result;
  logic [7:0]   fill_data;

  assign need_fill = !(MASK_REUSE != 0 && tbl_valid
                       && mask_byte == cached_r);
  assign last_lane = lane == 4'(LC - 1);
  assign done      = st_q == ROUND && last_lane
                     && round == 4'd10;
  assign flip      = fault_inject && !pass
                     && round == 4'(FAULT_ROUND);

  assign sh    = 7'(int'(lane) * LW);
  assign st_sh = ste << sh;

  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    assign raddr[8*j +: 8]        = st_sh[127-8*j -: 8];
    assign rd_msb[LW-1-8*j -: 8] = rdata[8*j +: 8];
  end

  assign rd_wide  = (128'(rd_msb) << (128 - LW)) >> sh;
  assign lmask    = ({128{1'b1}} << (128 - LW)) >> sh;
  assign sb_full  = (sb & ~lmask) | rd_wide;

  assign sr       = shift_rows(sb_full);
  assign nk       = next_round_key(rkey, round);
  assign st_new   = ((round == 4'd10) ? sr : mix_columns(sr))
                    ^ nk ^ {127'b0, flip};
  assign mask_new = (round == 4'd10) ? shift_rows(mask_reg)
                    : mix_columns(shift_rows(mask_reg));
  assign result   = st_new ^ mask_new;
  assign mismatch = FD && (result != res0);

  assign fill_data = aes_sbox(fill[7:0] ^ r_q) ^ r_q;

  aes_masked_sbox_table #(
    .LANES(SBOX_LANES)
  ) u_tbl (
    .clk  (clk),
    .we   (st_q == TBL_INIT),
    .waddr(fill[7:0]),
    .wdata(fill_data),
    .raddr(raddr),
    .rdata(rdata)
  );

  // controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // next-state decode
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:     if (in_valid)
                  st_d = need_fill ? TBL_INIT : ROUND;
      TBL_INIT: if (fill == 9'd255) st_d = ROUND;
      ROUND:    if (done && !(FD && !pass)) st_d = OUT;
      OUT:      if (out_ready) st_d = IDLE;
      default:  st_d = IDLE;
    endcase
  end

  // datapath: accept, table fill, lane-serial rounds, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ste       <= '0;
      ste_save  <= '0;
      rkey      <= '0;
      key_save  <= '0;
      mask_reg  <= '0;
      sb        <= '0;
      res0      <= '0;
      ct_q      <= '0;
      round     <= '0;
      lane      <= '0;
      fill      <= '0;
      r_q       <= '0;
      cached_r  <= '0;
      pass      <= 1'b0;
      tbl_valid <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: if (in_valid) begin
          ste      <= plaintext ^ key ^ {16{mask_byte}};
          if (FD) ste_save <= plaintext ^ key ^ {16{mask_byte}};
          rkey     <= key;
          key_save <= key;
          mask_reg <= {16{mask_byte}};
          r_q      <= mask_byte;
          round    <= 4'd1;
          lane     <= '0;
          pass     <= 1'b0;
          fill     <= '0;
          if (need_fill) tbl_valid <= 1'b0;
        end
        TBL_INIT: begin
          if (fill == 9'd255) begin
            tbl_valid <= 1'b1;
            cached_r  <= r_q;
          end else begin
            fill <= fill + 9'd1;
          end
        end
        ROUND: begin
          sb <= sb_full;
          if (!last_lane) begin
            lane <= lane + 4'd1;
          end else begin
            lane <= '0;
            if (done && FD && !pass) begin
              res0     <= result;
              ste      <= ste_save;
              rkey     <= key_save;
              mask_reg <= {16{r_q}};
              round    <= 4'd1;
              pass     <= 1'b1;
            end else if (done) begin
              ct_q    <= mismatch ? '0 : result;
              fault_q <= mismatch;
            end else begin
              ste      <= st_new;
              mask_reg <= mask_new;
              rkey     <= nk;
              round    <= round + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = st_q == IDLE;
  assign busy       = st_q != IDLE;
  assign out_valid  = st_q == OUT;
  assign ciphertext = ct_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_aes128_masked_lanes.sv
// Directed + random bench for aes128_masked_lanes across
// three configurations, against a byte-level AES model.
module tb_aes128_masked_lanes;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] plaintext, key;
  logic [7:0]   mask_byte;
  logic         fault_inject, out_ready;
  logic         iv [3];
  logic         irdy [3];
  logic         ov [3];
  logic         flt [3];
  logic         bsy [3];
  logic [127:0] ct [3];

  int tests = 0;
  int fails = 0;
  bit         tv [3];
  logic [7:0] cr [3];
  logic [7:0] sbt [256];

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_masked_lanes #(.SBOX_LANES(16), .FAULT_DETECT(0),
    .MASK_REUSE(1), .FAULT_ROUND(5)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .plaintext(plaintext), .key(key), .mask_byte(mask_byte),
    .fault_inject(fault_inject), .out_valid(ov[0]),
    .out_ready(out_ready), .ciphertext(ct[0]), .fault(flt[0]),
    .busy(bsy[0]));

  aes128_masked_lanes #(.SBOX_LANES(4), .FAULT_DETECT(0),
    .MASK_REUSE(1), .FAULT_ROUND(5)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .plaintext(plaintext), .key(key), .mask_byte(mask_byte),
    .fault_inject(fault_inject), .out_valid(ov[1]),
    .out_ready(out_ready), .ciphertext(ct[1]), .fault(flt[1]),
    .busy(bsy[1]));

  aes128_masked_lanes #(.SBOX_LANES(16), .FAULT_DETECT(1),
    .MASK_REUSE(1), .FAULT_ROUND(5)) ufd (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .plaintext(plaintext), .key(key), .mask_byte(mask_byte),
    .fault_inject(fault_inject), .out_valid(ov[2]),
    .out_ready(out_ready), .ciphertext(ct[2]), .fault(flt[2]),
    .busy(bsy[2]));

  function automatic logic [7:0] mul(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from brute-force inverse and the bitwise affine map
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
               ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] pt,
                                           input logic [127:0] k,
                                           input bit fi);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp, wd;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]],
               sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mul(a0, 2) ^ mul(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul(a1, 2) ^ mul(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul(a2, 2) ^ mul(a3, 3);
          s[4*c+3] = mul(a0, 3) ^ a1 ^ a2 ^ mul(a3, 2);
        end
      for (int i = 0; i < 16; i++) begin
        wd = w[4*rnd + i/4];
        s[i] = s[i] ^ wd[31-8*(i%4) -: 8];
      end
      if (fi && rnd == 5) s[15] = s[15] ^ 8'h01;
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic run(input int sel, input logic [127:0] pt,
                     input logic [127:0] k, input logic [7:0] r,
                     input bit fi, input bit stall, input string tag);
    int lat, lc, exp_lat;
    bit fd, fillx, got;
    logic [127:0] exp_ct, held;
    fd = (sel == 2);
    lc = (sel == 1) ? 4 : 1;
    fillx = !(tv[sel] && cr[sel] == r);
    exp_lat = 256 * int'(fillx) + (fd ? 2 : 1) * 10 * lc;
    exp_ct = (fd && fi) ? 128'h0 : ref_aes(pt, k, fi && !fd);
    @(negedge clk);
    chk({tag, ".in_ready"}, 128'(irdy[sel]), 128'd1);
    plaintext = pt; key = k; mask_byte = r;
    fault_inject = fi; iv[sel] = 1'b1;
    @(posedge clk);
    #1 iv[sel] = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 2000) begin
      @(posedge clk);
      #1 lat++;
      got = ov[sel];
    end
    fault_inject = 1'b0;
    chk({tag, ".latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, ".ct"}, ct[sel], exp_ct);
    chk({tag, ".fault"}, 128'(flt[sel]), 128'(fd && fi));
    chk({tag, ".busy"}, 128'(bsy[sel]), 128'd1);
    if (stall) begin
      held = ct[sel];
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        iv[sel] = (i % 2 == 0);
        @(posedge clk);
        #1 iv[sel] = 1'b0;
        chk({tag, ".hold_valid"}, 128'(ov[sel]), 128'd1);
        chk({tag, ".hold_ct"}, ct[sel], held);
        chk({tag, ".hold_in_ready"}, 128'(irdy[sel]), 128'd0);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 128'(ov[sel]), 128'd0);
    chk({tag, ".idle_after"}, 128'(bsy[sel]), 128'd0);
    tv[sel] = 1'b1;
    cr[sel] = r;
  endtask

  initial begin
    logic [127:0] rp, rk;
    logic [7:0] rr;
    int sel;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; tv[i] = 1'b0; cr[i] = 8'h00;
    end
    plaintext = '0; key = '0; mask_byte = '0;
    fault_inject = 1'b0; out_ready = 1'b0;
    build_sbox();
    chk("model.v1", ref_aes(PT1, K1, 1'b0), C1);
    #2 rst_n = 1'b0;
    #3;
    chk("rst.in_ready", 128'(irdy[0]), 128'd1);
    chk("rst.out_valid", 128'(ov[0]), 128'd0);
    chk("rst.ct", ct[0], 128'h0);
    chk("rst.fault", 128'(flt[0]), 128'd0);
    chk("rst.busy", 128'(bsy[0]), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(0, PT1, K1, 8'h5a, 1'b0, 1'b0, "t1");
    run(0, PT2, K2, 8'h5a, 1'b0, 1'b0, "t2_reuse");
    chk("t2.ct_fips", ct[0], C2);
    run(0, PT2, K2, 8'ha7, 1'b0, 1'b0, "t2_newmask");
    run(1, PT1, K1, 8'h5a, 1'b0, 1'b1, "t3_l4_stall");
    run(2, PT1, K1, 8'h5a, 1'b0, 1'b0, "t4_fd");
    run(2, PT1, K1, 8'h5a, 1'b1, 1'b0, "t4_fd_inj");
    run(0, PT1, K1, 8'ha7, 1'b1, 1'b0, "t5_inj");
    chk("t5.ct_differs", 128'(ct[0] != C1), 128'd1);
    run(1, PT2, K2, 8'hff, 1'b0, 1'b0, "mask_ff");
    run(0, PT2, K2, 8'h00, 1'b0, 1'b0, "mask_00");

    @(negedge clk);
    plaintext = PT1; key = K1; mask_byte = 8'h33; iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6.in_ready", 128'(irdy[0]), 128'd1);
    chk("t6.out_valid", 128'(ov[0]), 128'd0);
    chk("t6.ct", ct[0], 128'h0);
    chk("t6.fault", 128'(flt[0]), 128'd0);
    chk("t6.busy", 128'(bsy[0]), 128'd0);
    for (int i = 0; i < 3; i++) tv[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(0, PT1, K1, 8'h33, 1'b0, 1'b0, "t6_refill");

    for (int n = 0; n < 8; n++) begin
      sel = int'($urandom_range(0, 2));
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      rr = ($urandom_range(0, 1) == 0) ? cr[sel] : 8'($urandom);
      run(sel, rp, rk, rr, $urandom_range(0, 3) == 0, 1'b0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
